// File: rtl/pipeline_test_sequencer_pkg.sv
// Shared types and constants for the pipeline CPU test sequencer.
package pipeline_test_sequencer_pkg;

    // Sequencer phases, in the order a test walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESET = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // Read latency (cycles) of the program ROM and the expected-value ROM.
    localparam int unsigned ROM_LAT = 1;

endpackage

// File: rtl/pipeline_test_sequencer_index_counter.sv
// seq_index_counter: loadable up-counter that stops at a limit.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load_i     : load start_i (has priority over en_i)
//   en_i       : advance by one unless already at limit_i
//   start_i    : value loaded on load_i
//   limit_i    : last index of the phase; the count holds there
//   cnt_o      : current index (registered)
//   last_c     : cnt_o == limit_i (combinational)
module seq_index_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] start_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         last_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last_c = (cnt_q == limit_i);
    assign cnt_o  = cnt_q;

    // Compare-equal termination: the count never wraps past the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = start_i;
        end else if (en_i && !last_c) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_test_sequencer.sv
// Self-checking harness sequencer for the pipeline CPU: presets GPRs to
// their index, copies a program from ROM to instruction memory, runs the
// CPU out of reset for RUN_CYCLES clocks, then scans all GPRs against an
// expected-value ROM and reports the result.
//   clock, reset        : clock, async active-low reset
//   start               : one-cycle pulse, starts a test when idle
//   prog_addr/prog_data : program ROM port (data one cycle after address)
//   im_we/im_addr/im_wdata       : instruction memory write port
//   gpr_we/gpr_waddr/gpr_wdata   : GPR preset write port
//   gpr_raddr/gpr_rdata : GPR read port (combinational read)
//   exp_addr/exp_data   : expected ROM port (data one cycle after address)
//   cpu_reset           : active-low CPU reset, high only while running
//   busy/done/pass      : status; done and pass hold until the next start
//   fail_count          : mismatching registers (saturating)
//   first_fail          : lowest mismatching register, 0 when none
module pipeline_test_sequencer
    import pipeline_test_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned IM_AW      = 8,
    parameter int unsigned PROG_LEN   = 11,
    parameter int unsigned RUN_CYCLES = 100,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [IM_AW-1:0]      prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  im_we,
    output logic [IM_AW-1:0]      im_addr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    output logic                  gpr_we,
    output logic [REG_AW-1:0]     gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic [REG_AW-1:0]     gpr_raddr,
    input  logic [DATA_WIDTH-1:0] gpr_rdata,
    output logic [REG_AW-1:0]     exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [REG_AW-1:0]     fail_count,
    output logic [REG_AW-1:0]     first_fail
);

    localparam int unsigned       NUM_REGS  = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] FIRST_REG = REG_AW'(1);
    localparam logic [REG_AW-1:0] LAST_REG  = REG_AW'(NUM_REGS - 1);
    localparam logic [IM_AW-1:0]  LAST_PROG = IM_AW'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_RUN  = CNT_W'(RUN_CYCLES - 1);
    // exp_data is valid once exp_addr has moved ROM_LAT past the first index.
    localparam logic [REG_AW-1:0] CMP_FROM  = REG_AW'(1 + ROM_LAT);

    seq_state_e state_q, state_d;

    logic                  gpr_we_q, gpr_we_d;
    logic                  im_we_q, im_we_d;
    logic [IM_AW-1:0]      im_addr_q, im_addr_d;
    logic [REG_AW-1:0]     gpr_raddr_q, gpr_raddr_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [REG_AW-1:0]     fail_count_q, fail_count_d;
    logic [REG_AW-1:0]     first_fail_q, first_fail_d;

    logic                  pre_load, pre_en, pre_last;
    logic                  ld_load, ld_en, ld_last;
    logic                  run_load, run_en, run_last;
    logic                  chk_load, chk_en, chk_last;
    logic [REG_AW-1:0]     pre_cnt;
    logic [IM_AW-1:0]      ld_cnt;
    logic [CNT_W-1:0]      unused_run_cnt;
    logic [REG_AW-1:0]     chk_cnt;

    // GPR preset index: 1..NUM_REGS-1, doubles as write address and data.
    seq_index_counter #(.W(REG_AW)) u_pre_cnt (
        .clk     (clock),
        .rst_n   (reset),
        .load_i  (pre_load),
        .en_i    (pre_en),
        .start_i (FIRST_REG),
        .limit_i (LAST_REG),
        .cnt_o   (pre_cnt),
        .last_c  (pre_last)
    );

    // Program ROM address: 0..PROG_LEN-1.
    seq_index_counter #(.W(IM_AW)) u_ld_cnt (
        .clk     (clock),
        .rst_n   (reset),
        .load_i  (ld_load),
        .en_i    (ld_en),
        .start_i ('0),
        .limit_i (LAST_PROG),
        .cnt_o   (ld_cnt),
        .last_c  (ld_last)
    );

    // CPU run-time counter: 0..RUN_CYCLES-1.
    seq_index_counter #(.W(CNT_W)) u_run_cnt (
        .clk     (clock),
        .rst_n   (reset),
        .load_i  (run_load),
        .en_i    (run_en),
        .start_i ('0),
        .limit_i (LAST_RUN),
        .cnt_o   (unused_run_cnt),
        .last_c  (run_last)
    );

    // Expected ROM address: 1..NUM_REGS-1.
    seq_index_counter #(.W(REG_AW)) u_chk_cnt (
        .clk     (clock),
        .rst_n   (reset),
        .load_i  (chk_load),
        .en_i    (chk_en),
        .start_i (FIRST_REG),
        .limit_i (LAST_REG),
        .cnt_o   (chk_cnt),
        .last_c  (chk_last)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        gpr_we_d     = gpr_we_q;
        im_we_d      = im_we_q;
        im_addr_d    = im_addr_q;
        gpr_raddr_d  = gpr_raddr_q;
        cpu_reset_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        pre_load     = 1'b0;
        pre_en       = 1'b0;
        ld_load      = 1'b0;
        ld_en        = 1'b0;
        run_load     = 1'b0;
        run_en       = 1'b0;
        chk_load     = 1'b0;
        chk_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_PRESET;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    pre_load     = 1'b1;
                    gpr_we_d     = 1'b1;
                end
            end

            ST_PRESET: begin
                pre_en = 1'b1;
                if (pre_last) begin
                    state_d  = ST_LOAD;
                    gpr_we_d = 1'b0;
                    ld_load  = 1'b1;
                end
            end

            // The write trails the ROM address by one cycle; the last write
            // is the one whose address caught up with the held last address.
            ST_LOAD: begin
                ld_en     = 1'b1;
                im_we_d   = 1'b1;
                im_addr_d = ld_cnt;
                if (ld_last && im_we_q && (im_addr_q == ld_cnt)) begin
                    state_d     = ST_RUN;
                    im_we_d     = 1'b0;
                    run_load    = 1'b1;
                    cpu_reset_d = 1'b1;
                end
            end

            ST_RUN: begin
                run_en      = 1'b1;
                cpu_reset_d = 1'b1;
                if (run_last) begin
                    state_d     = ST_CHECK;
                    cpu_reset_d = 1'b0;
                    chk_load    = 1'b1;
                end
            end

            // gpr_raddr trails exp_addr by one cycle so both data arrive together.
            ST_CHECK: begin
                chk_en      = 1'b1;
                gpr_raddr_d = chk_cnt;
                if (chk_cnt >= CMP_FROM) begin
                    if (exp_data != gpr_rdata) begin
                        if (fail_count_q != '1) begin
                            fail_count_d = fail_count_q + REG_AW'(1);
                        end
                        if (first_fail_q == '0) begin
                            first_fail_d = gpr_raddr_q;
                        end
                    end
                    if (chk_last && (gpr_raddr_q == chk_cnt)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_count_q == '0);
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            gpr_we_q     <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            gpr_raddr_q  <= '0;
            cpu_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            gpr_we_q     <= gpr_we_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            gpr_raddr_q  <= gpr_raddr_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign prog_addr  = ld_cnt;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    // ROM data arrives in the write cycle itself, so it is forwarded, not
    // re-registered; gating keeps the bus at 0 outside writes.
    assign im_wdata   = im_we_q ? prog_data : '0;
    assign gpr_we     = gpr_we_q;
    assign gpr_waddr  = pre_cnt;
    assign gpr_wdata  = DATA_WIDTH'(pre_cnt);
    assign gpr_raddr  = gpr_raddr_q;
    assign exp_addr   = chk_cnt;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_pipeline_test_sequencer.sv
// Bench for pipeline_test_sequencer: two instances (11-word and 1-word
// programs) run side by side against ROM/GPR models and a stand-in CPU.
module tb_pipeline_test_sequencer;

    localparam int NI   = 2;
    localparam int NREG = 32;
    localparam int RUNC = 100;
    localparam int PLEN [NI] = '{11, 1};

    logic        clock, reset, start, log_clr;

    logic [7:0]  prog_addr [NI];
    logic [7:0]  im_addr   [NI];
    logic [31:0] prog_data [NI];
    logic [31:0] im_wdata  [NI];
    logic [31:0] gpr_wdata [NI];
    logic [31:0] gpr_rdata [NI];
    logic [31:0] exp_data  [NI];
    logic [4:0]  gpr_waddr [NI];
    logic [4:0]  gpr_raddr [NI];
    logic [4:0]  exp_addr  [NI];
    logic [4:0]  fail_count[NI];
    logic [4:0]  first_fail[NI];
    logic        im_we [NI], gpr_we [NI], cpu_reset [NI];
    logic        busy [NI], done [NI], pass [NI];

    logic [31:0] prog_rom  [NI][256];
    logic [31:0] exp_rom   [NI][NREG];
    logic [31:0] gpr       [NI][NREG];
    logic [31:0] cpu_final [NI][NREG];
    logic [31:0] cpu_mask  [NI];
    logic [31:0] im_log    [NI][256];

    int im_wr_cnt [NI], im_seq_err [NI], gpr_wr_cnt [NI], gpr_err [NI];
    int run_hi [NI], busy_cyc [NI];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipeline_test_sequencer #(.PROG_LEN(PLEN[g])) dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start),
            .prog_addr  (prog_addr[g]),
            .prog_data  (prog_data[g]),
            .im_we      (im_we[g]),
            .im_addr    (im_addr[g]),
            .im_wdata   (im_wdata[g]),
            .gpr_we     (gpr_we[g]),
            .gpr_waddr  (gpr_waddr[g]),
            .gpr_wdata  (gpr_wdata[g]),
            .gpr_raddr  (gpr_raddr[g]),
            .gpr_rdata  (gpr_rdata[g]),
            .exp_addr   (exp_addr[g]),
            .exp_data   (exp_data[g]),
            .cpu_reset  (cpu_reset[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .fail_count (fail_count[g]),
            .first_fail (first_fail[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational GPR read.
    always_comb begin
        for (int g = 0; g < NI; g++) gpr_rdata[g] = gpr[g][gpr_raddr[g]];
    end

    // Synchronous ROMs, GPR file, stand-in CPU and write-activity logs.
    always @(posedge clock) begin
        for (int g = 0; g < NI; g++) begin
            prog_data[g] <= prog_rom[g][prog_addr[g]];
            exp_data[g]  <= exp_rom[g][exp_addr[g]];
            if (gpr_we[g]) gpr[g][gpr_waddr[g]] <= gpr_wdata[g];
            if (cpu_reset[g]) begin
                for (int r = 1; r < NREG; r++)
                    if (cpu_mask[g][r]) gpr[g][r] <= cpu_final[g][r];
            end
            if (log_clr) begin
                im_wr_cnt[g]  <= 0;
                im_seq_err[g] <= 0;
                gpr_wr_cnt[g] <= 0;
                gpr_err[g]    <= 0;
                run_hi[g]     <= 0;
                busy_cyc[g]   <= 0;
            end else begin
                if (im_we[g]) begin
                    if (int'(im_addr[g]) != im_wr_cnt[g]) im_seq_err[g] <= im_seq_err[g] + 1;
                    im_log[g][im_addr[g]] <= im_wdata[g];
                    im_wr_cnt[g] <= im_wr_cnt[g] + 1;
                end
                if (gpr_we[g]) begin
                    if (int'(gpr_waddr[g]) != gpr_wr_cnt[g] + 1 ||
                        gpr_wdata[g] != 32'(gpr_wr_cnt[g] + 1))
                        gpr_err[g] <= gpr_err[g] + 1;
                    gpr_wr_cnt[g] <= gpr_wr_cnt[g] + 1;
                end
                if (cpu_reset[g]) run_hi[g] <= run_hi[g] + 1;
                if (busy[g]) busy_cyc[g] <= busy_cyc[g] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] out_vec(input int g);
        return {17'd0, im_we[g], gpr_we[g], cpu_reset[g], busy[g], done[g], pass[g],
                fail_count[g], first_fail[g], prog_addr[g], im_addr[g], gpr_waddr[g],
                gpr_raddr[g], exp_addr[g], im_wdata[g], gpr_wdata[g]};
    endfunction

    task automatic pulse_start();
        log_clr = 1'b1;
        @(negedge clock);
        log_clr = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // One full test on both instances; the model derives the final GPR
    // state from the presets and the stand-in CPU, then corrupts the
    // expected ROM at the registers flagged in 'corrupt'.
    task automatic run_test(input string name, input logic [31:0] corrupt, input bit extra_start);
        logic [31:0] model;
        int nfail, ffail, t, lat;
        for (int g = 0; g < NI; g++) begin
            for (int a = 0; a < 256; a++) prog_rom[g][a] = $urandom;
            cpu_mask[g] = ($urandom & ~32'h1) | 32'h2;
            for (int r = 0; r < NREG; r++) cpu_final[g][r] = $urandom;
            cpu_final[g][1] = 32'd5;
            for (int r = 0; r < NREG; r++) begin
                model = (r == 0) ? 32'd0 : (cpu_mask[g][r] ? cpu_final[g][r] : 32'(r));
                exp_rom[g][r] = corrupt[r] ? (model ^ ($urandom | 32'h1)) : model;
            end
        end
        prog_rom[1][0] = 32'h00430820;
        nfail = 0;
        ffail = 0;
        for (int r = 1; r < NREG; r++) begin
            if (corrupt[r]) begin
                nfail++;
                if (ffail == 0) ffail = r;
            end
        end

        pulse_start();
        if (extra_start) begin
            t = 0;
            while (!im_we[0] && t < 100) begin
                @(negedge clock);
                t++;
            end
            check_eq({name, ".load_reached"}, 128'(im_we[0]), 128'(1));
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        t = 0;
        while (!(done[0] && done[1]) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check_eq({name, ".done_in_bound"}, 128'(t < 2000), 128'(1));
        repeat (3) @(negedge clock);

        for (int g = 0; g < NI; g++) begin
            lat = (NREG - 1) + (PLEN[g] + 1) + RUNC + NREG + 1;
            check_eq($sformatf("%s.i%0d.done", name, g), 128'(done[g]), 128'(1));
            check_eq($sformatf("%s.i%0d.busy", name, g), 128'(busy[g]), 128'(0));
            check_eq($sformatf("%s.i%0d.pass", name, g), 128'(pass[g]), 128'(nfail == 0));
            check_eq($sformatf("%s.i%0d.fail_count", name, g), 128'(fail_count[g]), 128'(nfail));
            check_eq($sformatf("%s.i%0d.first_fail", name, g), 128'(first_fail[g]), 128'(ffail));
            check_eq($sformatf("%s.i%0d.cpu_reset", name, g), 128'(cpu_reset[g]), 128'(0));
            check_eq($sformatf("%s.i%0d.im_writes", name, g), 128'(im_wr_cnt[g]), 128'(PLEN[g]));
            check_eq($sformatf("%s.i%0d.im_order", name, g), 128'(im_seq_err[g]), 128'(0));
            check_eq($sformatf("%s.i%0d.gpr_writes", name, g), 128'(gpr_wr_cnt[g]), 128'(NREG - 1));
            check_eq($sformatf("%s.i%0d.gpr_values", name, g), 128'(gpr_err[g]), 128'(0));
            check_eq($sformatf("%s.i%0d.run_cycles", name, g), 128'(run_hi[g]), 128'(RUNC));
            check_eq($sformatf("%s.i%0d.latency", name, g), 128'(busy_cyc[g]), 128'(lat));
            for (int a = 0; a < PLEN[g]; a++)
                check_eq($sformatf("%s.i%0d.im[%0d]", name, g, a), 128'(im_log[g][a]), 128'(prog_rom[g][a]));
        end
    endtask

    initial begin
        int t;
        reset   = 1'b0;
        start   = 1'b0;
        log_clr = 1'b0;
        for (int g = 0; g < NI; g++) begin
            cpu_mask[g] = 32'd0;
            for (int a = 0; a < 256; a++) prog_rom[g][a] = 32'd0;
            for (int r = 0; r < NREG; r++) exp_rom[g][r] = 32'd0;
        end

        repeat (2) @(negedge clock);
        for (int g = 0; g < NI; g++)
            check_eq($sformatf("in_reset.i%0d.outputs", g), out_vec(g), 128'(0));
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            for (int g = 0; g < NI; g++)
                check_eq($sformatf("idle%0d.i%0d.outputs", c, g), out_vec(g), 128'(0));
        end

        run_test("basic", 32'd0, 1'b0);
        run_test("bad7_12", (32'd1 << 7) | (32'd1 << 12), 1'b0);
        run_test("all_bad", 32'hFFFF_FFFE, 1'b0);
        for (int k = 0; k < 3; k++)
            run_test($sformatf("rnd%0d", k), $urandom & $urandom & $urandom & ~32'h1, 1'b0);

        // Abort 40 cycles into RUN with an asynchronous reset.
        pulse_start();
        t = 0;
        while (!cpu_reset[0] && t < 200) begin
            @(negedge clock);
            t++;
        end
        check_eq("abort.run_reached", 128'(cpu_reset[0]), 128'(1));
        repeat (40) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("abort.i%0d.cpu_reset", g), 128'(cpu_reset[g]), 128'(0));
            check_eq($sformatf("abort.i%0d.busy", g), 128'(busy[g]), 128'(0));
            check_eq($sformatf("abort.i%0d.done", g), 128'(done[g]), 128'(0));
            check_eq($sformatf("abort.i%0d.outputs", g), out_vec(g), 128'(0));
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int g = 0; g < NI; g++)
            check_eq($sformatf("abort.i%0d.idle_after", g), out_vec(g), 128'(0));

        run_test("rerun", 32'd0, 1'b0);
        run_test("restart_in_load", 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
